// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operation sequencer: operand and
// result widths, operation encodings and FSM state codes.
package calc_pkg;

  localparam int WIDTH = 16;          // adder operand width (only 16 supported)
  localparam int RES_W = 2 * WIDTH;   // full product / result width

  // Operation encodings presented by the keypad/operation decoder.
  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  // FSM state codes, kept as plain constants for compatibility with the
  // existing calculator blocks that decode them.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADD      = 3'd1;
  localparam logic [2:0] ST_SUB_NEG  = 3'd2;
  localparam logic [2:0] ST_SUB_ADD  = 3'd3;
  localparam logic [2:0] ST_MUL_STEP = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  // Number of shift-and-add iterations needed for a full unsigned product.
  localparam int MUL_STEPS = WIDTH;

endpackage : calc_pkg

// File: rtl/calc_op_sequencer.sv
// Multi-cycle controller that owns the calculator's shared ripple adder.
// Runs ADD in one compute cycle, SUB as two's-complement negate + add in two
// cycles, and (when CALC_MUL_EN is defined) an unsigned 16x16 shift-and-add
// multiply in sixteen cycles. Reports the result with a one-cycle done pulse.
// Optional feature macro: CALC_MUL_EN (undefined: MUL reports err like op 11).
module calc_op_sequencer
  import calc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  output logic [WIDTH-1:0]   adder_input1,
  output logic [WIDTH-1:0]   adder_input2,
  input  logic [RES_W-1:0]   adder_output,
  output logic               busy,
  output logic               done,
  output logic [RES_W-1:0]   result,
  output logic               neg,
  output logic               err
);

  logic [2:0]       state;
  logic [WIDTH-1:0] a_q;      // operand_a latched on accept
  logic [WIDTH-1:0] b_q;      // operand_b latched on accept
  logic [WIDTH-1:0] tmp_q;    // -b produced by the SUB_NEG pass

`ifdef CALC_MUL_EN
  logic [WIDTH-1:0] p_hi;     // upper half of the running product
  logic [WIDTH-1:0] p_lo;     // lower half; starts as the multiplier b
  logic [3:0]       cnt;      // completed multiply steps, wraps 15 -> 0
  logic [WIDTH:0]   mul_sum;  // carry + sum of the current partial add

  assign mul_sum = adder_output[WIDTH:0];
`endif

  // Status flags are pure decodes of the registered state, so they are glitch
  // free and drop to 0 the instant an asynchronous reset forces IDLE.
  always_comb begin
    busy = (state == ST_ADD) || (state == ST_SUB_NEG) || (state == ST_SUB_ADD)
`ifdef CALC_MUL_EN
        || (state == ST_MUL_STEP)
`endif
        ;
    done = (state == ST_DONE);
  end

  // Drive the adder operands for the current compute state; idle otherwise.
  always_comb begin
    // NOTE: defaults assigned before the case so every path drives both
    // outputs; a missing branch would otherwise infer a latch.
    adder_input1 = '0;
    adder_input2 = '0;
    case (state)
      ST_ADD: begin
        adder_input1 = a_q;
        adder_input2 = b_q;
      end
      ST_SUB_NEG: begin
        adder_input1 = ~b_q;
        adder_input2 = WIDTH'(1);
      end
      ST_SUB_ADD: begin
        adder_input1 = a_q;
        adder_input2 = tmp_q;
      end
`ifdef CALC_MUL_EN
      ST_MUL_STEP: begin
        adder_input1 = p_hi;
        adder_input2 = p_lo[0] ? a_q : '0;
      end
`endif
      default: ;
    endcase
  end

  // Sequencer FSM: accept a request in IDLE, walk the compute states while
  // capturing the adder output each edge, then pulse DONE for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      tmp_q  <= '0;
      result <= '0;
      neg    <= 1'b0;
      err    <= 1'b0;
`ifdef CALC_MUL_EN
      p_hi   <= '0;
      p_lo   <= '0;
      cnt    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples
      // the pre-edge values, independent of statement order.
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q <= operand_a;
            b_q <= operand_b;
            neg <= 1'b0;
            err <= 1'b0;
            case (op)
              OP_ADD: state <= ST_ADD;
              OP_SUB: state <= ST_SUB_NEG;
`ifdef CALC_MUL_EN
              OP_MUL: begin
                p_hi  <= '0;
                p_lo  <= operand_b;
                cnt   <= '0;
                state <= ST_MUL_STEP;
              end
`endif
              // Reserved (or MUL when the multiplier is not built): report
              // an error with a zero result on the very next cycle.
              default: begin
                err    <= 1'b1;
                result <= '0;
                state  <= ST_DONE;
              end
            endcase
          end
        end

        ST_ADD: begin
          result <= adder_output;
          state  <= ST_DONE;
        end

        // ~b + 1 gives -b modulo 2^16; b == 0 wraps to 0 so a - 0 == a.
        ST_SUB_NEG: begin
          tmp_q <= adder_output[WIDTH-1:0];
          state <= ST_SUB_ADD;
        end

        ST_SUB_ADD: begin
          result <= {{(RES_W-WIDTH){1'b0}}, adder_output[WIDTH-1:0]};
          neg    <= (a_q < b_q);
          state  <= ST_DONE;
        end

`ifdef CALC_MUL_EN
        // Add a into the high half when the current multiplier bit is set,
        // then shift the 33-bit {carry, P_hi, P_lo} right by one.
        ST_MUL_STEP: begin
          p_hi <= mul_sum[WIDTH:1];
          p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
          cnt  <= cnt + 4'd1;
          if (cnt == 4'(MUL_STEPS - 1)) begin
            result <= {mul_sum, p_lo[WIDTH-1:1]};
            state  <= ST_DONE;
          end
        end
`endif

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : calc_op_sequencer

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
Multi-cycle operation controller for the calculator's shared 16-bit ripple adder.
- Accepts one operation request (ADD/SUB/MUL) and drives the adder's two operand inputs each cycle.
- Accumulates the adder output into internal registers and returns a 32-bit result with a one-cycle done pulse.
- Sits between the keypad/operation decoder and the display path. It is the sole master of the adder.

Parameters:
WIDTH, 16, operand width; must equal the adder input width. Only 16 is supported.
RES_W, 32, result width; localparam fixed at 2*WIDTH, not overridable.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request strobe; sampled only in IDLE
op  input  2  00 ADD, 01 SUB, 10 MUL, 11 reserved
operand_a  input  16  first operand, latched on accepted start
operand_b  input  16  second operand, latched on accepted start
adder_input1  output  16  to adder operand 1
adder_input2  output  16  to adder operand 2
adder_output  input  32  from adder; bits [16:0] meaningful (carry at bit 16)
busy  output  1  high from the cycle after accept until done
done  output  1  one-cycle pulse, result valid
result  output  32  registered result, held until next accept
neg  output  1  SUB only: operand_a < operand_b (unsigned)
err  output  1  valid with done; reserved or disabled op

Behaviour:
- Reset values: all outputs 0, state IDLE, internal registers 0. Reset mid-operation aborts immediately, with no done pulse.
- Adder is combinational. Each compute state drives adder_input1/2 and captures adder_output at the clock edge.
- In IDLE and DONE, adder inputs are driven to 0.
- Accept: state==IDLE && start. Latch op, operand_a and operand_b; clear neg and err. start while busy or in DONE is ignored, with no queuing.
- States: IDLE, ADD, SUB_NEG, SUB_ADD, MUL_STEP, DONE. DONE lasts one cycle (done=1), then returns to IDLE.
- Timing: accept edge = T. busy=1 in every compute-state cycle; done=1, busy=0 in DONE.
- ADD: ADD at T+1, driving in1=a and in2=b. result <= adder_output. DONE at T+2.
- SUB:
  - SUB_NEG at T+1: in1=~b, in2=16'h0001; tmp <= adder_output[15:0].
  - SUB_ADD at T+2: in1=a, in2=tmp; result <= {16'h0, adder_output[15:0]}; neg <= (a<b).
  - DONE at T+3. The b==0 case must yield result=a, neg=0.
- MUL (shift-and-add, unsigned):
  - Registers P_hi[15:0], P_lo[15:0] (P_lo init = b) and step counter cnt[3:0] = 0.
  - Each MUL_STEP: in1=P_hi, in2 = P_lo[0] ? a : 0. Then {P_hi, P_lo} <= {adder_output[16:0], P_lo[15:1]} (17+15 bits).
  - After 16 steps (cnt wraps 15→0), result <= {P_hi, P_lo}. MUL_STEP spans T+1..T+16; DONE at T+17.
- op==11: go straight to DONE at T+1, with err=1 and result=0.
- Result and neg hold their last value until the next accepted start; err clears on accept.

Optional Feature:
CALC_MUL_EN
- Defined: MUL path, P_hi/P_lo/cnt registers and MUL_STEP state are present.
- Undefined: MUL logic is not synthesized. op==10 is treated like op==11 (DONE at T+1, err=1, result=0).

Decomposition:
- Shared package calc_pkg: op encodings (OP_ADD, OP_SUB, OP_MUL, OP_RSVD), state enum, WIDTH and RES_W constants.
- Single module; no sub-module needed. The adder stays a separate instance wired externally by the parent.

Test Plan:
- Reset: hold rst_n=0 with start=1 → all outputs 0. After release, ADD 16'hFFFF+16'h0001 → done at T+2, result=32'h0001_0000, err=0.
- SUB 16'h0005-16'h0007 → done at T+3, result=32'h0000_FFFE, neg=1. SUB 16'h1234-16'h0000 → result=32'h0000_1234, neg=0.
- MUL 16'hFFFF×16'hFFFF → done exactly at T+17, result=32'hFFFE_0001. MUL 16'h0000×16'h1234 → result 0.
- start pulsed during an active MUL with different operands → ignored; original product returned, single done pulse.
- op=11 → done at T+1 with err=1, result=0. Without CALC_MUL_EN, op=10 behaves identically.
- rst_n asserted at MUL step 8 → outputs 0 asynchronously, no done. A following ADD 3+4 gives result=7 at T+2.
